// File: rtl/crc_16_pkg.sv
// Shared definitions for the bit-serial CRC-16/ANSI datapath and its bench model.
//   crc_16_hash      16-bit CRC register type
//   CRC16_ANSI_POLY  generator polynomial 0x8005 (implicit x^16 omitted)
//   CRC16_ANSI_INIT  register value after reset
//   crc_16_step      advances a CRC by one message bit (MSB-first shift, no reflection)
package crc_16_pkg;

    typedef logic [15:0] crc_16_hash;

    localparam crc_16_hash CRC16_ANSI_POLY = 16'h8005;
    localparam crc_16_hash CRC16_ANSI_INIT = 16'h0000;

    // The polynomial argument defaults to the ANSI value so callers that only
    // care about CRC-16/ANSI can use the two-argument form.
    function automatic crc_16_hash crc_16_step(
        input logic       data_bit,
        input crc_16_hash crc,
        input crc_16_hash poly = CRC16_ANSI_POLY
    );
        logic       fb;
        crc_16_hash shifted;
        fb      = data_bit ^ crc[15];
        shifted = {crc[14:0], 1'b0};
        return fb ? (shifted ^ poly) : shifted;
    endfunction

endpackage

// File: rtl/crc_16_ansi.sv
// Bit-serial CRC-16/ANSI generator/checker. One message bit is consumed on every
// rising edge while reset is low; the raw register (no reflection, no final XOR)
// is presented directly on data_o.
// Ports:
//   clk_i   clock, all state changes on the rising edge
//   rst_i   synchronous active-high reset, loads CRC_INIT, wins over data_i
//   data_i  message bit, sampled every non-reset edge
//   data_o  current CRC register contents
module crc_16_ansi
    import crc_16_pkg::*;
#(
    parameter crc_16_hash POLY     = CRC16_ANSI_POLY,
    parameter crc_16_hash CRC_INIT = CRC16_ANSI_INIT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_i,
    output logic [15:0] data_o
);

    crc_16_hash crc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_16_step(data_i, crc_q, POLY);
        end
    end

    assign data_o = crc_q;

endmodule

// File: tb/tb_crc_16_ansi.sv
// Self-checking bench for crc_16_ansi. Each driven cycle optionally pushes the
// expected register value into a scoreboard; the entry is popped and compared
// just after the rising edge that should produce it.
module tb_crc_16_ansi;
    import crc_16_pkg::*;

    typedef struct {
        string      tag;
        crc_16_hash value;
    } sb_entry_t;

    logic        clk;
    logic        rst;
    logic        data_in;
    logic [15:0] data_out;

    sb_entry_t   sb_q[$];
    crc_16_hash  model;
    int          n_tests;
    int          n_fail;

    crc_16_ansi dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data_in),
        .data_o (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, advance the model, optionally score the result.
    task automatic tick(input logic r, input logic d, input bit check, input string tag);
        sb_entry_t e;
        rst     = r;
        data_in = d;
        model   = r ? CRC16_ANSI_INIT : crc_16_step(d, model);
        if (check) begin
            e.tag   = tag;
            e.value = model;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (check) begin
            e = sb_q.pop_front();
            n_tests++;
            assert (data_out === e.value) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, data_out, e.value);
            end
        end
    endtask

    // Directed check against a literal value known independently of the model.
    task automatic check_const(input string tag, input logic [15:0] expected);
        n_tests++;
        assert (data_out === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, data_out, expected);
        end
    endtask

    initial begin
        logic [31:0] word;
        n_tests = 0;
        n_fail  = 0;
        model   = CRC16_ANSI_INIT;
        rst     = 1'b1;
        data_in = 1'b0;

        // 1: reset value, then a run of zero bits leaves the register at zero
        tick(1'b1, 1'b0, 1'b1, "reset");
        check_const("reset_const", 16'h0000);
        for (int i = 0; i < 32; i++) tick(1'b0, 1'b0, 1'b1, "zeros");
        check_const("zeros_const", 16'h0000);

        // 2: single one bit, then a zero
        tick(1'b1, 1'b0, 1'b0, "");
        tick(1'b0, 1'b1, 1'b1, "one");
        check_const("one_const", 16'h8005);
        tick(1'b0, 1'b0, 1'b1, "one_zero");
        check_const("one_zero_const", 16'h800F);

        // 3: two ones, second cancels the feedback
        tick(1'b1, 1'b0, 1'b0, "");
        tick(1'b0, 1'b1, 1'b0, "");
        check_const("ones_1", 16'h8005);
        tick(1'b0, 1'b1, 1'b1, "ones_2");
        check_const("ones_2_const", 16'h000A);

        // 4: reset mid-message discards state
        tick(1'b1, 1'b0, 1'b0, "");
        tick(1'b0, 1'b1, 1'b0, "");
        tick(1'b0, 1'b0, 1'b0, "");
        check_const("mid_pre", 16'h800F);
        tick(1'b1, 1'b1, 1'b1, "mid_reset");
        check_const("mid_reset_const", 16'h0000);
        tick(1'b0, 1'b1, 1'b1, "mid_restart");
        check_const("mid_restart_const", 16'h8005);

        // 5: reset dominates toggling data
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, logic'(i[0]), 1'b1, "hold_reset");
            check_const("hold_reset_const", 16'h0000);
        end

        // 6: random 32-bit words, LSB first, checked after the last bit
        for (int w = 0; w < 100; w++) begin
            word = $urandom();
            tick(1'b1, 1'b0, 1'b0, "");
            for (int b = 0; b < 32; b++) begin
                tick(1'b0, word[b], (b == 31), "rand_word");
            end
        end

        n_tests++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
